// File: rtl/fa_21bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fa_21bit_pkg
// Description : Shared constants and helpers for the fa_21bit adder:
//               default operand width, carry-lookahead group size, and the
//               number of groups needed to cover a given width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fa_21bit_pkg;

  localparam int FA_WIDTH  = 21;
  localparam int CLA_GROUP = 4;

  // Number of CLA groups covering 'width' bits; the last may be partial.
  function automatic int fa_group_count(input int width);
    return (width + CLA_GROUP - 1) / CLA_GROUP;
  endfunction

endpackage : fa_21bit_pkg
`default_nettype wire

// File: rtl/fa_21bit_cla4_group.sv
`default_nettype none
// ============================================================================
// Module      : cla4_group
// Description : One 4-bit carry-lookahead group. Produces the group sum,
//               group generate and group propagate. Bits outside i_mask are
//               padding: they generate nothing, propagate unconditionally
//               and contribute a zero sum bit, so a partial top group still
//               reports the carry out of its last valid bit.
// Ports       : i_a, i_b   - 4-bit operand slices
//               i_cin      - carry into bit 0 of the group
//               i_mask     - 1 marks a valid bit position
//               o_sum      - 4-bit sum (padding bits forced to 0)
//               o_g, o_p   - group generate / propagate
// Revision    : 1.0 - initial release
// ============================================================================
module cla4_group
  import fa_21bit_pkg::*;
(
  input  logic [CLA_GROUP-1:0] i_a,
  input  logic [CLA_GROUP-1:0] i_b,
  input  logic                 i_cin,
  input  logic [CLA_GROUP-1:0] i_mask,
  output logic [CLA_GROUP-1:0] o_sum,
  output logic                 o_g,
  output logic                 o_p
);

  logic [CLA_GROUP-1:0] w_g;
  logic [CLA_GROUP-1:0] w_p;
  logic [CLA_GROUP-1:0] w_c;

  always_comb begin
    w_g = i_a & i_b & i_mask;
    // Padding bits propagate so the group carry passes straight through them.
    w_p = (i_a ^ i_b) | ~i_mask;

    w_c[0] = i_cin;
    w_c[1] = w_g[0] | (w_p[0] & i_cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
        | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    o_p = &w_p;

    o_sum = (i_a ^ i_b ^ w_c) & i_mask;
  end

endmodule : cla4_group
`default_nettype wire

// File: rtl/fa_21bit.sv
`default_nettype none
// ============================================================================
// Module      : fa_21bit
// Description : Parameterized adder {cout, S} = A + B + cin built from 4-bit
//               carry-lookahead groups with a rippled group carry, plus a
//               registered copy of the result and a signed-overflow flag.
// Ports       : clk, rst_n  - clock, synchronous active-low reset
//               A, B, cin   - operands and carry in
//               en          - register load enable
//               S, cout     - combinational sum and carry out
//               S_q, cout_q - registered sum and carry out
//               ovf_q       - registered signed overflow
//               valid_q     - a result has been loaded since reset
// Revision    : 1.0 - initial release
// ============================================================================
module fa_21bit
  import fa_21bit_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic [WIDTH-1:0] S_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             valid_q
);

  localparam int NG = fa_group_count(WIDTH);
  localparam int PW = NG * CLA_GROUP;

  logic [PW-1:0] w_a_pad;
  logic [PW-1:0] w_b_pad;
  logic [PW-1:0] w_mask;
  logic [PW-1:0] w_sum_pad;
  logic [NG-1:0] w_g;
  logic [NG-1:0] w_p;
  logic [NG:0]   w_c;
  logic          w_ovf;

  always_comb begin
    w_a_pad            = '0;
    w_b_pad            = '0;
    w_a_pad[WIDTH-1:0] = A;
    w_b_pad[WIDTH-1:0] = B;
  end

  for (genvar i = 0; i < PW; i++) begin : g_mask
    assign w_mask[i] = (i < WIDTH);
  end

  assign w_c[0] = cin;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4_group u_grp (
      .i_a    (w_a_pad[k*CLA_GROUP +: CLA_GROUP]),
      .i_b    (w_b_pad[k*CLA_GROUP +: CLA_GROUP]),
      .i_cin  (w_c[k]),
      .i_mask (w_mask[k*CLA_GROUP +: CLA_GROUP]),
      .o_sum  (w_sum_pad[k*CLA_GROUP +: CLA_GROUP]),
      .o_g    (w_g[k]),
      .o_p    (w_p[k])
    );
    // Group carry ripple; the group's own carry out is this same term.
    assign w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
  end

  // Padding sum bits of a partial top group are always zero and not needed.
  if (PW > WIDTH) begin : g_pad
    logic [PW-WIDTH-1:0] w_pad_unused;
    assign w_pad_unused = w_sum_pad[PW-1:WIDTH];
  end

  assign S     = w_sum_pad[WIDTH-1:0];
  assign cout  = w_c[NG];
  assign w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      S_q     <= S;
      cout_q  <= cout;
      ovf_q   <= w_ovf;
      valid_q <= 1'b1;
    end
  end

endmodule : fa_21bit
`default_nettype wire

// File: tb/tb_fa_21bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fa_21bit
// Description : Self-checking bench for fa_21bit. Compares against plain
//               integer arithmetic (A + B + cin, signed range test for
//               overflow) for widths 21, 5, 4 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fa_21bit;
  import fa_21bit_pkg::*;

  localparam int W = FA_WIDTH;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n, en;

  logic [W-1:0] a21, b21, s21, sq21;
  logic         c21, co21, coq21, ovq21, vq21;
  logic [4:0]   a5, b5, s5, sq5;
  logic         c5, co5, coq5, ovq5, vq5;
  logic [3:0]   a4, b4, s4, sq4;
  logic         c4, co4, coq4, ovq4, vq4;
  logic [0:0]   a1, b1, s1, sq1;
  logic         c1, co1, coq1, ovq1, vq1;

  fa_21bit #(.WIDTH(W)) u_dut21 (
    .clk(clk), .rst_n(rst_n), .A(a21), .B(b21), .cin(c21), .en(en),
    .S(s21), .cout(co21), .S_q(sq21), .cout_q(coq21), .ovf_q(ovq21), .valid_q(vq21));
  fa_21bit #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .A(a5), .B(b5), .cin(c5), .en(en),
    .S(s5), .cout(co5), .S_q(sq5), .cout_q(coq5), .ovf_q(ovq5), .valid_q(vq5));
  fa_21bit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .cin(c4), .en(en),
    .S(s4), .cout(co4), .S_q(sq4), .cout_q(coq4), .ovf_q(ovq4), .valid_q(vq4));
  fa_21bit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .cin(c1), .en(en),
    .S(s1), .cout(co1), .S_q(sq1), .cout_q(coq1), .ovf_q(ovq1), .valid_q(vq1));

  int checks = 0;
  int errors = 0;

  // Expected registered state of the 21-bit instance.
  logic [W:0] m_res;
  logic       m_ovf;
  logic       m_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_sum(input longint a, input longint b, input int c);
    return 64'(a + b + longint'(c));
  endfunction

  // Overflow = the true signed sum falls outside the w-bit two's-complement range.
  function automatic logic ref_ovf(input longint a, input longint b, input int c, input int w);
    longint half, sa, sb, t;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    t    = sa + sb + longint'(c);
    return (t > half - 1) || (t < -half);
  endfunction

  // Called just after a rising edge: drive, check combinational result,
  // load on the next edge and check the registered copy.
  task automatic step21(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input string tag);
    a21 = a; b21 = b; c21 = c; en = 1'b1;
    #10;
    check({tag, " comb"}, 64'({co21, s21}), ref_sum(longint'(a), longint'(b), int'(c)));
    @(posedge clk); #1;
    m_res   = (W+1)'(ref_sum(longint'(a), longint'(b), int'(c)));
    m_ovf   = ref_ovf(longint'(a), longint'(b), int'(c), W);
    m_valid = 1'b1;
    check({tag, " reg"},   64'({coq21, sq21}), 64'(m_res));
    check({tag, " ovf_q"}, 64'(ovq21), 64'(m_ovf));
    check({tag, " valid"}, 64'(vq21), 64'(m_valid));
  endtask

  initial begin
    a5 = '0; b5 = '0; c5 = 1'b0;
    a4 = '0; b4 = '0; c4 = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;

    // Reset with enable high: reset wins.
    rst_n = 1'b0; en = 1'b1;
    a21 = W'($urandom); b21 = W'($urandom); c21 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst S_q",     64'(sq21),  64'(0));
    check("rst cout_q",  64'(coq21), 64'(0));
    check("rst ovf_q",   64'(ovq21), 64'(0));
    check("rst valid_q", 64'(vq21),  64'(0));
    check("rst comb", 64'({co21, s21}), ref_sum(longint'(a21), longint'(b21), 1));

    rst_n = 1'b1;

    // Boundary cases.
    step21(21'h1FFFFF, 21'h000000, 1'b1, "ripple");
    check("ripple S_q const",  64'({coq21, sq21}), 64'(22'h200000));
    check("ripple ovf const",  64'(ovq21), 64'(0));
    step21(21'h0FFFFF, 21'h000001, 1'b0, "sovf");
    check("sovf S_q const",    64'({coq21, sq21}), 64'(22'h100000));
    check("sovf ovf const",    64'(ovq21), 64'(1));
    step21(21'h1FFFFF, 21'h1FFFFF, 1'b1, "maxsum");
    check("maxsum S_q const",  64'({coq21, sq21}), 64'(22'h3FFFFF));
    check("maxsum ovf const",  64'(ovq21), 64'(0));
    step21(21'h100000, 21'h100000, 1'b0, "negovf");

    // Load, hold with en=0, then reset with en=1.
    step21(21'd5, 21'd7, 1'b0, "load12");
    check("load12 S_q const", 64'(sq21), 64'(12));
    en = 1'b0; a21 = 21'd100; b21 = 21'd200; c21 = 1'b1;
    #10;
    check("hold comb", 64'({co21, s21}), 64'(301));
    @(posedge clk); #1;
    check("hold S_q",    64'(sq21), 64'(12));
    check("hold valid",  64'(vq21), 64'(1));
    rst_n = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    check("rst2 S_q",    64'(sq21),  64'(0));
    check("rst2 cout_q", 64'(coq21), 64'(0));
    check("rst2 ovf_q",  64'(ovq21), 64'(0));
    check("rst2 valid",  64'(vq21),  64'(0));
    check("rst2 comb",   64'({co21, s21}), 64'(301));
    rst_n = 1'b1;

    // Random stress.
    for (int n = 0; n < 60; n++) begin
      step21(W'($urandom), W'($urandom), 1'($urandom), "rand");
    end

    // Exhaustive sweep for the narrow instances (registers held).
    en = 1'b0;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        for (int c = 0; c < 2; c++) begin
          a5 = 5'(a);     b5 = 5'(b);     c5 = 1'(c);
          a4 = 4'(a);     b4 = 4'(b);     c4 = 1'(c);
          a1 = 1'(a);     b1 = 1'(b);     c1 = 1'(c);
          #1;
          check("w5 comb", 64'({co5, s5}), ref_sum(longint'(a % 32), longint'(b % 32), c));
          check("w4 comb", 64'({co4, s4}), ref_sum(longint'(a % 16), longint'(b % 16), c));
          check("w1 comb", 64'({co1, s1}), ref_sum(longint'(a % 2),  longint'(b % 2),  c));
        end
      end
    end

    // Registered path of the narrow instances.
    @(posedge clk); #1;
    a5 = 5'h0F; b5 = 5'h01; c5 = 1'b0;
    a4 = 4'h8;  b4 = 4'hF;  c4 = 1'b1;
    a1 = 1'b0;  b1 = 1'b0;  c1 = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;
    check("w5 reg", 64'({coq5, sq5}), ref_sum(15, 1, 0));
    check("w5 ovf", 64'(ovq5), 64'(ref_ovf(15, 1, 0, 5)));
    check("w5 valid", 64'(vq5), 64'(1));
    check("w4 reg", 64'({coq4, sq4}), ref_sum(8, 15, 1));
    check("w4 ovf", 64'(ovq4), 64'(ref_ovf(8, 15, 1, 4)));
    check("w4 valid", 64'(vq4), 64'(1));
    check("w1 reg", 64'({coq1, sq1}), ref_sum(0, 0, 1));
    check("w1 ovf", 64'(ovq1), 64'(ref_ovf(0, 0, 1, 1)));
    check("w1 valid", 64'(vq1), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fa_21bit
`default_nettype wire

// File: doc/fa_21bit.md
# fa_21bit

Parameterized binary adder, default 21 bits: `{cout, S} = A + B + cin`. A combinational sum path is built from 4-bit carry-lookahead groups, with a registered copy of the result and a signed-overflow flag. It is a leaf arithmetic block used wherever a wide add with carry-in and carry-out is needed.

## Interface
- `width`, default 21: operand and sum bit width; any integer ≥ 1.
- `clk`  in  1: single clock; all registers update on rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on rising `clk`.
- `A`  in  width: operand A, unsigned or two's complement.
- `B`  in  width: operand B.
- `cin`  in  1: carry input.
- `en`  in  1: register load enable.
- `S`  out  width: combinational sum, `(A + B + cin) mod 2^width`.
- `cout`  out  1: combinational carry out of bit `width-1`.
- `S_q`  out  width: registered `S`.
- `cout_q`  out  1: registered `cout`.
- `ovf_q`  out  1: registered signed overflow.
- `valid_q`  out  1: high once a result has been loaded since reset.
- Clocking: one clock (`clk`); reset (`rst_n`) is synchronous and active-low.

## Operation
- Width rule: `{cout, S}` is exactly the `width+1`-bit value of `A + B + cin`, with no truncation of the carry.
- Signed overflow: `ovf = (A[width-1] == B[width-1]) && (S[width-1] != A[width-1])`.
- Carry chain:
  - Operands are split into `ceil(width/4)` groups of 4 bits, LSB first.
  - Each group computes bit generate/propagate, its internal carries, and group G/P.
  - Group carries ripple: `c[k+1] = G[k] | (P[k] & c[k])`, with `c[0] = cin`.
  - The top group may be partial (1 bit when width = 21) and must use only valid bits.
- Combinational outputs `S` and `cout` are pure functions of `A`, `B`, `cin`. They do not depend on `clk`, `rst_n`, or `en`.
- Register behaviour on each rising `clk`:
  - `rst_n = 0`: `S_q`, `cout_q`, `ovf_q`, `valid_q` all go to 0. Reset overrides `en`.
  - `rst_n = 1`, `en = 1`: `S_q` ← `S`, `cout_q` ← `cout`, `ovf_q` ← `ovf`, `valid_q` ← 1.
  - `rst_n = 1`, `en = 0`: all registered outputs hold.
- No X propagation from registers after reset. Combinational outputs are X only if inputs are X.

## Timing
- `S` and `cout`: zero-cycle latency, combinational. They must settle well within 10 ns of any input change; the critical path is about `ceil(width/4)` group carry stages.
- Registered outputs: 1-cycle latency. Operands present at rising edge N appear on `S_q`/`cout_q`/`ovf_q` after edge N.
- Reset mid-operation: the next edge with `rst_n = 0` clears the registers regardless of `en`. Combinational outputs keep tracking the inputs.
- Input changes between edges affect only the combinational outputs.

## Structure
- Sub-module `cla4_group`:
  - Inputs: 4-bit a, 4-bit b, carry in, and a valid-bit count or mask for the partial top group.
  - Outputs: 4-bit sum, group G, group P, carry out.
- `fa_21bit` instantiates the groups in a generate loop, chains the carries, and holds the output register and overflow logic.
- Shared package holds:
  - default width constant `FA_WIDTH = 21`;
  - group size constant `CLA_GROUP = 4`;
  - a function returning the group count.

## Test plan
- Random stress: 50+ vectors with `A`, `B` random 21-bit values and `cin` random, checked against `A + B + cin` at 22 bits. Both `{cout, S}` (10 ns after each change) and `{cout_q, S_q}` (one edge after loading with `en = 1`) must match exactly.
- Full carry ripple: `A = 21'h1FFFFF`, `B = 0`, `cin = 1` → `S = 0`, `cout = 1`, and `ovf_q = 0` after the edge.
- Signed overflow: `A = 21'h0FFFFF`, `B = 21'h000001`, `cin = 0` → `S = 21'h100000`, `cout = 0`, `ovf_q = 1`.
- Max sum: `A = B = 21'h1FFFFF`, `cin = 1` → `S = 21'h1FFFFF`, `cout = 1`, `ovf_q = 0`.
- Reset and enable: load `A = 5`, `B = 7`, `cin = 0` → `S_q = 12`, `valid_q = 1`. Then:
  - `en = 0` with new inputs → registered outputs hold 12;
  - `rst_n = 0` together with `en = 1` → all registered outputs become 0 on the next edge.
- Parameter sweep: width = 1, 4, 5, 21, exhaustive or random against the reference sum. Covers the partial top group and the width = 1 edge case.
